pipe_latch_skid: RTL and testbench
==================================

# pipe_latch_skid

Parametrised pipeline stage register for the 5-stage processor, replacing the fixed free-running 32-bit stage latches. It carries NUM_LANES data lanes of DATA_W bits plus an overflow flag. It adds valid/ready flow control through a 2-entry skid buffer with a fully registered in_ready, and synchronous flush that inserts a bubble. It sits between any two pipeline stages (F/D, D/X, X/M, M/W) and lets a later stage stall an earlier one without a combinational ready path.

## Interface
- DATA_W, 32, width of one lane
- NUM_LANES, 4, number of lanes (e.g. pc, o, d, ins)
- INS_LANE, 3, index of the lane holding the instruction; forced to NOP_INS on a bubble
- NOP_INS, 32'h0000_0000, instruction value presented while out_valid=0
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered
- in_data  input  NUM_LANES*DATA_W  packed lanes, lane k at [k*DATA_W +: DATA_W]
- in_ovf  input  1  overflow flag accompanying in_data
- out_valid  output  1  out_data/out_ovf hold a valid entry
- out_ready  input  1  downstream accepts
- out_data  output  NUM_LANES*DATA_W  packed lanes of head entry, or the bubble
- out_ovf  output  1  overflow flag of head entry; 0 on a bubble

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Two entry registers: MAIN (head, drives outputs) and SKID. Each entry is NUM_LANES lanes plus ovf.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. In-transfer: MAIN<=in, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - In and out both: MAIN<=in, stay in ONE.
    - In only: SKID<=in, go to FULL.
    - Out only: go to EMPTY.
    - Neither: hold.
  - FULL: out_valid=1, in_ready=0. Out-transfer: MAIN<=SKID, go to ONE. Otherwise hold.
- Order is strictly FIFO. No entry is duplicated or dropped except on flush.
- Bubble output: when out_valid=0, out_data lane INS_LANE = NOP_INS, all other lanes = 0, out_ovf = 0.
- Flush: state goes to EMPTY next cycle. An in-transfer in the same cycle is accepted and discarded. An out-transfer in the same cycle completes normally.
- Priority: reset_n=0 > flush > handshake.
- Entry registers load only on the listed events. They are not required to clear, but outputs must show the bubble whenever out_valid=0.

## Timing
- Reset (reset_n low at a clock edge): state EMPTY. Next cycle: out_valid=0, in_ready=1, out_data=bubble, out_ovf=0.
- Latency: an entry accepted in cycle N is on out_data with out_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready and out_valid are decoded only from the state flops. Neither has a combinational path from in_valid, out_ready or flush.
- in_ready falls the cycle after the second entry is taken while stalled. The skid entry absorbs the transfer already in flight.
- Asserting reset mid-operation discards all entries, with the same result as flush plus the reset output values.

## Structure
- Shared pipeline package:
  - state enum {EMPTY, ONE, FULL}
  - default NOP_INS constant
  - lane-slice helper constants
- One sub-module, pipe_entry_reg: one entry (NUM_LANES*DATA_W + 1 bits) with load enable and a synchronous reset to 0. It is instantiated twice, for MAIN and SKID.
- The state register, next-state logic and bubble mux live in pipe_latch_skid.

## Test plan
- Reset/idle: hold reset_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1, out_data lane 3 = 32'h0, out_ovf=0.
- Stream: out_ready=1, feed A=32'h11, B=32'h22, C=32'h33 on consecutive cycles -> same values appear one cycle later in order, in_ready stays 1.
- Stall/skid: out_ready=0, push A then B -> in_ready=0 from the cycle after B. Raise out_ready -> A, then B, with no loss. in_ready=1 again after A leaves.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, bubble on out_data, held and incoming entries never appear.
- Overflow passthrough: in_ovf=1 with entry D, in_ovf=0 with E -> out_ovf=1 for D, 0 for E, 0 when out_valid=0.
- Parameter sweep: DATA_W=16, NUM_LANES=2, INS_LANE=0, NOP_INS=16'hFFFF -> bubble shows lane0=16'hFFFF, lane1=0. Stream and stall checks pass.

Source files
------------

// File: rtl/pipe_latch_skid_pkg.sv
// Shared pipeline-stage definitions: skid-buffer states, default bubble
// instruction and lane geometry helpers.
package pipe_latch_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INS_DEFAULT   = 32'h0000_0000;
  localparam int          DEFAULT_DATA_W    = 32;
  localparam int          DEFAULT_NUM_LANES = 4;
  localparam int          DEFAULT_INS_LANE  = 3;

  // Bit offset of a lane inside a packed lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (lanes plus overflow flag) with load enable and
// synchronous active-low clear.
module pipe_entry_reg #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline stage register with 2-entry skid buffer, registered in_ready,
// synchronous flush and bubble insertion on the instruction lane.
module pipe_latch_skid
  import pipe_latch_skid_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                NUM_LANES = DEFAULT_NUM_LANES,
  parameter int                INS_LANE  = DEFAULT_INS_LANE,
  parameter logic [DATA_W-1:0] NOP_INS   = DATA_W'(NOP_INS_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  input  logic                        in_ovf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic                        out_ovf
);

  localparam int ENTRY_W = NUM_LANES * DATA_W + 1;

  state_t               state_reg, state_next;
  logic [ENTRY_W-1:0]   in_entry, main_d, main_q, skid_q;
  logic                 main_load, skid_load;
  logic                 in_xfer, out_xfer;

  // Handshake outputs come straight from the state flops.
  assign in_ready  = (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign in_entry = {in_ovf, in_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    main_d     = in_entry;
    if (flush) begin
      // Incoming entry is taken but dropped; loads are suppressed.
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load  = 1'b1;
            state_next = ST_FULL;
          end else if (out_xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d     = skid_q;
            main_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .d       (main_d),
    .q       (main_q)
  );

  pipe_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .d       (in_entry),
    .q       (skid_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [DATA_W-1:0] BUBBLE = (gi == INS_LANE) ? NOP_INS : '0;
      assign out_data[lane_lsb(gi, DATA_W) +: DATA_W] =
        out_valid ? main_q[lane_lsb(gi, DATA_W) +: DATA_W] : BUBBLE;
    end
  endgenerate

  assign out_ovf = out_valid & main_q[ENTRY_W-1];

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Directed bench for pipe_latch_skid: default geometry plus a 16-bit,
// 2-lane instance with a non-zero NOP on lane 0.
module tb_pipe_latch_skid;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Default instance: 4 x 32, INS_LANE=3, NOP=0
  logic         flush0, in_valid0, in_ready0, in_ovf0, out_valid0, out_ready0, out_ovf0;
  logic [127:0] in_data0, out_data0;

  // Sweep instance: 2 x 16, INS_LANE=0, NOP=FFFF
  logic         flush1, in_valid1, in_ready1, in_ovf1, out_valid1, out_ready1, out_ovf1;
  logic [31:0]  in_data1, out_data1;

  pipe_latch_skid dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ovf(in_ovf0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ovf(out_ovf0)
  );

  pipe_latch_skid #(.DATA_W(16), .NUM_LANES(2), .INS_LANE(0), .NOP_INS(16'hFFFF)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_ovf(in_ovf1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_ovf(out_ovf1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane 3 carries the instruction value; other lanes are tagged copies.
  function automatic logic [127:0] pk0(input logic [31:0] v);
    return {v, v | 32'h1000, v | 32'h2000, v | 32'h3000};
  endfunction

  function automatic logic [31:0] pk1(input logic [15:0] v);
    return {v ^ 16'h5A00, v};
  endfunction

  initial begin
    reset_n = 1'b0;
    flush0 = 0; in_valid0 = 0; in_data0 = '0; in_ovf0 = 0; out_ready0 = 0;
    flush1 = 0; in_valid1 = 0; in_data1 = '0; in_ovf1 = 0; out_ready1 = 0;
    step(); step();
    reset_n = 1'b1;

    // Reset / idle
    check("rst_out_valid", 128'(out_valid0), 128'd0);
    check("rst_in_ready",  128'(in_ready0),  128'd1);
    check("rst_bubble",    out_data0,        128'h0);
    check("rst_ovf",       128'(out_ovf0),   128'd0);

    // Stream A, B, C with out_ready held high
    out_ready0 = 1; in_valid0 = 1; in_data0 = pk0(32'h11);
    step();
    check("stream_a",       out_data0,        pk0(32'h11));
    check("stream_a_valid", 128'(out_valid0), 128'd1);
    check("stream_rdy_a",   128'(in_ready0),  128'd1);
    in_data0 = pk0(32'h22);
    step();
    check("stream_b",       out_data0,        pk0(32'h22));
    check("stream_rdy_b",   128'(in_ready0),  128'd1);
    in_data0 = pk0(32'h33);
    step();
    check("stream_c",       out_data0,        pk0(32'h33));
    in_valid0 = 0;
    step();
    check("stream_drain",   128'(out_valid0), 128'd0);
    check("stream_bubble",  out_data0,        128'h0);

    // Stall: A then B while out_ready low
    out_ready0 = 0; in_valid0 = 1; in_data0 = pk0(32'hA1);
    step();
    check("stall_rdy_after_a", 128'(in_ready0), 128'd1);
    in_data0 = pk0(32'hB2);
    step();
    check("stall_rdy_full",  128'(in_ready0), 128'd0);
    check("stall_head_a",    out_data0,       pk0(32'hA1));
    in_data0 = pk0(32'hC3);   // offered but not taken while full
    step();
    check("stall_hold_a",    out_data0,       pk0(32'hA1));
    check("stall_hold_rdy",  128'(in_ready0), 128'd0);
    in_valid0 = 0; out_ready0 = 1;
    step();
    check("stall_out_b",     out_data0,       pk0(32'hB2));
    check("stall_rdy_again", 128'(in_ready0), 128'd1);
    step();
    check("stall_empty",     128'(out_valid0), 128'd0);

    // Flush while FULL with an incoming entry
    out_ready0 = 0; in_valid0 = 1; in_data0 = pk0(32'h44);
    step();
    in_data0 = pk0(32'h55);
    step();
    check("flush_pre_full", 128'(in_ready0), 128'd0);
    flush0 = 1; in_data0 = pk0(32'h66);
    step();
    check("flush_valid",  128'(out_valid0), 128'd0);
    check("flush_bubble", out_data0,        128'h0);
    check("flush_rdy",    128'(in_ready0),  128'd1);
    flush0 = 0; in_valid0 = 0; out_ready0 = 1;
    step();
    check("flush_no_ghost", 128'(out_valid0), 128'd0);

    // Flush in ONE while the head is leaving
    in_valid0 = 1; in_data0 = pk0(32'h68);
    step();
    check("flush_one_head", out_data0, pk0(32'h68));
    flush0 = 1; in_data0 = pk0(32'h69);
    step();
    check("flush_one_valid", 128'(out_valid0), 128'd0);
    flush0 = 0; in_valid0 = 0;

    // Overflow passthrough
    in_valid0 = 1; in_data0 = pk0(32'h77); in_ovf0 = 1;
    step();
    check("ovf_d",      128'(out_ovf0), 128'd1);
    check("ovf_d_data", out_data0,      pk0(32'h77));
    in_data0 = pk0(32'h88); in_ovf0 = 0;
    step();
    check("ovf_e",      128'(out_ovf0), 128'd0);
    check("ovf_e_data", out_data0,      pk0(32'h88));
    in_valid0 = 1; in_data0 = pk0(32'h99); in_ovf0 = 1;
    step();
    in_valid0 = 0; in_ovf0 = 0;
    step();
    check("ovf_bubble", 128'(out_ovf0), 128'd0);

    // Mid-operation reset discards a held entry
    out_ready0 = 0; in_valid0 = 1; in_data0 = pk0(32'hAA); in_ovf0 = 1;
    step();
    in_valid0 = 0; in_ovf0 = 0; reset_n = 0;
    step();
    reset_n = 1;
    check("midrst_valid", 128'(out_valid0), 128'd0);
    check("midrst_rdy",   128'(in_ready0),  128'd1);
    check("midrst_ovf",   128'(out_ovf0),   128'd0);
    out_ready0 = 1;
    step();
    check("midrst_gone",  128'(out_valid0), 128'd0);

    // Parameter sweep instance
    check("p_bubble", 128'(out_data1), 128'h0000_FFFF);
    out_ready1 = 1; in_valid1 = 1; in_data1 = pk1(16'h0101);
    step();
    check("p_stream_a", 128'(out_data1), 128'(pk1(16'h0101)));
    in_data1 = pk1(16'h0202);
    step();
    check("p_stream_b", 128'(out_data1), 128'(pk1(16'h0202)));
    out_ready1 = 0; in_data1 = pk1(16'h0303);
    step();
    check("p_stall_rdy", 128'(in_ready1), 128'd0);
    check("p_stall_head", 128'(out_data1), 128'(pk1(16'h0202)));
    in_valid1 = 0; out_ready1 = 1;
    step();
    check("p_stall_out", 128'(out_data1), 128'(pk1(16'h0303)));
    step();
    check("p_drain_bubble", 128'(out_data1), 128'h0000_FFFF);
    check("p_drain_valid",  128'(out_valid1), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
